// File: rtl/baud_gen_frac.sv
// Runtime-programmable baud tick generator with an integer+fractional divisor.
// Produces an oversample tick, a bit tick every OVS oversample ticks, and the current phase.
module baud_gen_frac #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OVS      = 16,
  parameter int DIV_RST  = 651,
  parameter int FRAC_RST = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [DIV_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  input  logic                    div_load,
  output logic                    div_busy,
  input  logic                    sync,
  output logic                    os_tick,
  output logic                    bit_tick,
  output logic [$clog2(OVS)-1:0]  os_phase
);

  localparam int PH_W = $clog2(OVS);
  localparam logic [DIV_W-1:0]  RST_INT  = (DIV_RST < 2) ? DIV_W'(2) : DIV_W'(DIV_RST);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(FRAC_RST);
  localparam logic [PH_W-1:0]   MID_PH   = PH_W'(OVS / 2);
  localparam logic [PH_W-1:0]   LAST_PH  = PH_W'(OVS - 1);

  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [DIV_W-1:0]  pend_int;
  logic [FRAC_W-1:0] pend_frac;
  logic              busy;
  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              ext;
  logic [PH_W-1:0]   phase;

  logic [DIV_W-1:0]  term;
  logic [FRAC_W:0]   frac_sum;
  logic [DIV_W-1:0]  load_int;
  logic              apply;

  // The fractional carry from the previous tick stretches the current period by one cycle.
  always_comb begin
    term     = act_int - DIV_W'(1) + DIV_W'(ext);
    frac_sum = {1'b0, acc} + {1'b0, act_frac};
    load_int = (div_int < DIV_W'(2)) ? DIV_W'(2) : div_int;
    os_tick  = en & (cnt == term);
    bit_tick = os_tick & (phase == LAST_PH);
    apply    = busy & (sync | ~en | os_tick);
    div_busy = busy;
    os_phase = phase;
  end

  // A fresh capture keeps busy set even when the older pending value is applied this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_int  <= RST_INT;
      pend_frac <= RST_FRAC;
      busy      <= 1'b0;
      act_int   <= RST_INT;
      act_frac  <= RST_FRAC;
    end else begin
      if (div_load) begin
        pend_int  <= load_int;
        pend_frac <= div_frac;
        busy      <= 1'b1;
      end else if (apply) begin
        busy <= 1'b0;
      end
      if (apply) begin
        act_int  <= pend_int;
        act_frac <= pend_frac;
      end
    end
  end

  // Sync overrides the tick update; an applied divisor always restarts the period at cnt=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      acc   <= '0;
      ext   <= 1'b0;
      phase <= '0;
    end else if (sync) begin
      cnt   <= '0;
      acc   <= '0;
      ext   <= 1'b0;
      phase <= MID_PH;
    end else if (apply) begin
      cnt <= '0;
      acc <= '0;
      ext <= 1'b0;
      if (os_tick) begin
        phase <= phase + PH_W'(1);
      end
    end else if (os_tick) begin
      cnt   <= '0;
      acc   <= frac_sum[FRAC_W-1:0];
      ext   <= frac_sum[FRAC_W];
      phase <= phase + PH_W'(1);
    end else if (en) begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed self-checking bench for baud_gen_frac with hand-computed tick positions.
module tb_baud_gen_frac;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_load;
  logic        div_busy;
  logic        sync;
  logic        os_tick;
  logic        bit_tick;
  logic [3:0]  os_phase;

  int vectors;
  int miscompares;

  baud_gen_frac #(
    .DIV_W(16), .FRAC_W(4), .OVS(16), .DIV_RST(651), .FRAC_RST(1)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .div_int(div_int), .div_frac(div_frac),
    .div_load(div_load), .div_busy(div_busy), .sync(sync), .os_tick(os_tick),
    .bit_tick(bit_tick), .os_phase(os_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Load with en=0 so the divisor is applied on the cycle after capture, cnt restarting at 0.
  task automatic do_load(input logic [15:0] i, input logic [3:0] f);
    en       = 1'b0;
    div_int  = i;
    div_frac = f;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    step();
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b0; div_int = '0; div_frac = '0; div_load = 1'b0; sync = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    vectors++;
    if (os_tick !== 1'b0 || bit_tick !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ticks: os=%b bit=%b required 0 0", os_tick, bit_tick);
    end
    vectors++;
    if (div_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_busy: got %b required 0", div_busy);
    end
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (os_tick !== 1'b0 || os_phase !== 4'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_run k=%0d: os=%b phase=%0d required 0 0", k, os_tick, os_phase);
      end
      step();
    end
    en = 1'b0;
  endtask

  task automatic test_integer;
    logic ex_os, ex_bt;
    do_load(16'd4, 4'd0);
    en = 1'b1;
    for (int k = 0; k < 128; k++) begin
      ex_os = (k % 4 == 3);
      ex_bt = (k == 63) || (k == 127);
      vectors++;
      if (os_tick !== ex_os || bit_tick !== ex_bt || os_phase !== 4'((k / 4) % 16)) begin
        miscompares++;
        $display("[TB] FAIL int4 k=%0d: os=%b bit=%b phase=%0d required %b %b %0d",
                 k, os_tick, bit_tick, os_phase, ex_os, ex_bt, (k / 4) % 16);
      end
      step();
    end
    en = 1'b0;
  endtask

  task automatic test_fraction;
    int tk[16] = '{3, 7, 12, 16, 21, 25, 30, 34, 39, 43, 48, 52, 57, 61, 66, 70};
    int n;
    logic ex_os;
    n = 0;
    do_load(16'd4, 4'd8);
    en = 1'b1;
    for (int k = 0; k <= 72; k++) begin
      ex_os = 1'b0;
      foreach (tk[j]) if (tk[j] == k) ex_os = 1'b1;
      if (os_tick === 1'b1) n++;
      vectors++;
      if (os_tick !== ex_os) begin
        miscompares++;
        $display("[TB] FAIL frac k=%0d: os=%b required %b", k, os_tick, ex_os);
      end
      step();
    end
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("[TB] FAIL frac_count: got %0d ticks required 16", n);
    end
    en = 1'b0;
  endtask

  task automatic test_reload;
    logic ex_os, ex_busy;
    do_load(16'd4, 4'd0);
    en = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      ex_os   = (k == 3) || (k == 9) || (k == 15);
      ex_busy = (k == 2) || (k == 3);
      vectors++;
      if (os_tick !== ex_os || div_busy !== ex_busy) begin
        miscompares++;
        $display("[TB] FAIL reload k=%0d: os=%b busy=%b required %b %b",
                 k, os_tick, div_busy, ex_os, ex_busy);
      end
      if (k == 1) begin
        div_int = 16'd6; div_frac = 4'd0; div_load = 1'b1;
      end else begin
        div_load = 1'b0;
      end
      step();
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic ex_os, ex_busy;
    do_load(16'd4, 4'd0);
    en = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      ex_os   = (k == 3) || (k == 6) || (k == 9);
      ex_busy = (k >= 1) && (k <= 3);
      vectors++;
      if (os_tick !== ex_os || div_busy !== ex_busy) begin
        miscompares++;
        $display("[TB] FAIL b2b k=%0d: os=%b busy=%b required %b %b",
                 k, os_tick, div_busy, ex_os, ex_busy);
      end
      div_load = (k == 0) || (k == 1);
      div_int  = (k == 0) ? 16'd5 : 16'd3;
      step();
    end
    div_load = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_sync;
    logic ex_os, ex_bt;
    do_load(16'd4, 4'd0);
    en = 1'b1;
    step(); step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      ex_os = (k % 4 == 3);
      ex_bt = (k == 31);
      vectors++;
      if (os_tick !== ex_os || bit_tick !== ex_bt || os_phase !== 4'((8 + k / 4) % 16)) begin
        miscompares++;
        $display("[TB] FAIL sync k=%0d: os=%b bit=%b phase=%0d required %b %b %0d",
                 k, os_tick, bit_tick, os_phase, ex_os, ex_bt, (8 + k / 4) % 16);
      end
      step();
    end
    en = 1'b0;
  endtask

  task automatic test_enable;
    logic [3:0] held;
    do_load(16'd4, 4'd0);
    en = 1'b1;
    step(); step();
    held = 4'd0;
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      vectors++;
      if (os_tick !== 1'b0 || bit_tick !== 1'b0 || os_phase !== held) begin
        miscompares++;
        $display("[TB] FAIL en_hold k=%0d: os=%b bit=%b phase=%0d required 0 0 %0d",
                 k, os_tick, bit_tick, os_phase, held);
      end
    end
    en = 1'b1;
    vectors++;
    if (os_tick !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL en_resume0: os=%b required 0", os_tick);
    end
    step();
    vectors++;
    if (os_tick !== 1'b1 || os_phase !== held) begin
      miscompares++;
      $display("[TB] FAIL en_resume1: os=%b phase=%0d required 1 %0d", os_tick, os_phase, held);
    end
    step();
    vectors++;
    if (os_tick !== 1'b0 || os_phase !== held + 4'd1) begin
      miscompares++;
      $display("[TB] FAIL en_resume2: os=%b phase=%0d required 0 %0d", os_tick, os_phase, held + 4'd1);
    end
    en = 1'b0;
  endtask

  task automatic test_clamp_reset;
    do_load(16'd0, 4'd0);
    en = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      vectors++;
      if (os_tick !== (k % 2 == 1)) begin
        miscompares++;
        $display("[TB] FAIL clamp k=%0d: os=%b required %b", k, os_tick, (k % 2 == 1));
      end
      step();
    end
    div_int = 16'd4; div_load = 1'b1;
    step();
    div_load = 1'b0;
    vectors++;
    if (div_busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL busy_before_reset: got %b required 1", div_busy);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (div_busy !== 1'b0 || os_phase !== 4'd0 || os_tick !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: busy=%b phase=%0d os=%b required 0 0 0", div_busy, os_phase, os_tick);
    end
    step();
    reset = 1'b0;
    en = 1'b1;
    for (int k = 0; k <= 652; k++) begin
      if (os_tick !== (k == 650) || div_busy !== 1'b0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL rst_period k=%0d: os=%b busy=%b required %b 0", k, os_tick, div_busy, (k == 650));
      end else if (k == 650) begin
        vectors++;
      end
      step();
    end
    en = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_integer();
    test_fraction();
    test_reload();
    test_back_to_back();
    test_sync();
    test_enable();
    test_clamp_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
